// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared JTAG definitions for the TAP controller and the
//               instruction decoder: TAP state encoding, IR width, opcodes
//               and the Capture-IR pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    // Instruction register width in bits (must be at least 2).
    localparam int IR_size = 3;

    // 16 TAP controller states, 4-bit encoding.
    typedef enum logic [3:0] {
        TLR     = 4'h0,
        RTI     = 4'h1,
        SelDR   = 4'h2,
        CapDR   = 4'h3,
        ShDR    = 4'h4,
        Ex1DR   = 4'h5,
        PauseDR = 4'h6,
        Ex2DR   = 4'h7,
        UpdDR   = 4'h8,
        SelIR   = 4'h9,
        CapIR   = 4'hA,
        ShIR    = 4'hB,
        Ex1IR   = 4'hC,
        PauseIR = 4'hD,
        Ex2IR   = 4'hE,
        UpdIR   = 4'hF
    } tap_state_t;

    // Instruction opcodes.
    localparam logic [IR_size-1:0] EXTEST         = 3'b000;
    localparam logic [IR_size-1:0] SAMPLE_PRELOAD = 3'b010;
    localparam logic [IR_size-1:0] INTEST         = 3'b011;
    localparam logic [IR_size-1:0] RUNBIST        = 3'b100;
    localparam logic [IR_size-1:0] IDCODE         = 3'b101;
    localparam logic [IR_size-1:0] BYPASS         = 3'b111;

    // Pattern loaded into the IR shift stage in Capture-IR (LSBs are 01).
    localparam logic [IR_size-1:0] IR_CAPTURE     = 3'b001;

endpackage
`default_nettype wire

// File: rtl/tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tap_fsm
// Description : IEEE 1149.1 TAP state register, next-state logic and the
//               combinational data-register control decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tms,
    output tap_state_t o_state,
    output tap_state_t o_next_state,
    output logic       o_shift_dr,
    output logic       o_clock_dr,
    output logic       o_update_dr
);

    tap_state_t r_state;
    tap_state_t w_next_state;

    // Next-state function of the TAP graph, selected by TMS.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TLR:     w_next_state = i_tms ? TLR     : RTI;
            RTI:     w_next_state = i_tms ? SelDR   : RTI;
            SelDR:   w_next_state = i_tms ? SelIR   : CapDR;
            CapDR:   w_next_state = i_tms ? Ex1DR   : ShDR;
            ShDR:    w_next_state = i_tms ? Ex1DR   : ShDR;
            Ex1DR:   w_next_state = i_tms ? UpdDR   : PauseDR;
            PauseDR: w_next_state = i_tms ? Ex2DR   : PauseDR;
            Ex2DR:   w_next_state = i_tms ? UpdDR   : ShDR;
            UpdDR:   w_next_state = i_tms ? SelDR   : RTI;
            SelIR:   w_next_state = i_tms ? TLR     : CapIR;
            CapIR:   w_next_state = i_tms ? Ex1IR   : ShIR;
            ShIR:    w_next_state = i_tms ? Ex1IR   : ShIR;
            Ex1IR:   w_next_state = i_tms ? UpdIR   : PauseIR;
            PauseIR: w_next_state = i_tms ? Ex2IR   : PauseIR;
            Ex2IR:   w_next_state = i_tms ? UpdIR   : ShIR;
            UpdIR:   w_next_state = i_tms ? SelDR   : RTI;
            default: w_next_state = TLR;
        endcase
    end

    // State register; reset takes priority over TMS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TLR;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign o_state      = r_state;
    assign o_next_state = w_next_state;

    // DR controls are pure decodes of the current state, so no added latency.
    assign o_shift_dr  = (r_state == ShDR);
    assign o_clock_dr  = !((r_state == CapDR) || (r_state == ShDR));
    assign o_update_dr = (r_state == UpdDR);

endmodule
`default_nettype wire

// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tap_controller
// Description : IEEE 1149.1 TAP controller: state machine, instruction
//               register (shift stage + latched instruction) and the
//               registered TDO mux between IR and selected DR.
//               Build option TAP_IDCODE_RESET_EN: when defined, reset and
//               Test-Logic-Reset load IDCODE instead of BYPASS.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_controller
    import jtag_pkg::*;
#(
    parameter int                  IR_size    = jtag_pkg::IR_size,
    parameter logic [IR_size-1:0]  IR_CAPTURE = jtag_pkg::IR_CAPTURE,
    parameter logic [IR_size-1:0]  BYPASS     = jtag_pkg::BYPASS,
    parameter logic [IR_size-1:0]  IDCODE     = jtag_pkg::IDCODE
) (
    input  logic               TCK,
    input  logic               reset,
    input  logic               TMS,
    input  logic               TDI,
    input  logic               TDO_DR,
    output logic               TDO,
    output logic               enableTDO,
    output logic               shiftDR,
    output logic               clockDR,
    output logic               updateDR,
    output logic [IR_size-1:0] instruction,
    output logic [3:0]         tap_state
);

`ifdef TAP_IDCODE_RESET_EN
    localparam logic [IR_size-1:0] c_reset_instr = IDCODE;
`else
    localparam logic [IR_size-1:0] c_reset_instr = BYPASS;
`endif

    tap_state_t         w_state;
    tap_state_t         w_next_state;
    logic [IR_size-1:0] r_ir_shift;
    logic [IR_size-1:0] r_instruction;
    logic               r_tdo;
    logic               r_enable_tdo;

    tap_fsm u_tap_fsm (
        .clk          (TCK),
        .rst          (reset),
        .i_tms        (TMS),
        .o_state      (w_state),
        .o_next_state (w_next_state),
        .o_shift_dr   (shiftDR),
        .o_clock_dr   (clockDR),
        .o_update_dr  (updateDR)
    );

    // IR shift stage: capture the fixed pattern, shift right with TDI into MSB, else hold.
    always_ff @(posedge TCK) begin
        if (reset) begin
            r_ir_shift <= IR_CAPTURE;
        end else begin
            case (w_state)
                CapIR:   r_ir_shift <= IR_CAPTURE;
                ShIR:    r_ir_shift <= {TDI, r_ir_shift[IR_size-1:1]};
                default: r_ir_shift <= r_ir_shift;
            endcase
        end
    end

    // Active instruction: forced to the reset opcode on entry to / stay in TLR, latched in UpdIR.
    always_ff @(posedge TCK) begin
        if (reset) begin
            r_instruction <= c_reset_instr;
        end else if (w_next_state == TLR) begin
            r_instruction <= c_reset_instr;
        end else if (w_state == UpdIR) begin
            r_instruction <= r_ir_shift;
        end
    end

    // Registered TDO mux; TDO keeps its last value outside the shift states.
    always_ff @(posedge TCK) begin
        if (reset) begin
            r_tdo        <= 1'b0;
            r_enable_tdo <= 1'b0;
        end else if (w_state == ShIR) begin
            r_tdo        <= r_ir_shift[0];
            r_enable_tdo <= 1'b1;
        end else if (w_state == ShDR) begin
            r_tdo        <= TDO_DR;
            r_enable_tdo <= 1'b1;
        end else begin
            r_enable_tdo <= 1'b0;
        end
    end

    assign TDO         = r_tdo;
    assign enableTDO   = r_enable_tdo;
    assign instruction = r_instruction;
    assign tap_state   = w_state;

endmodule
`default_nettype wire

// File: tb/tb_tap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_controller
// Description : Self-checking bench for tap_controller: directed scenarios
//               plus randomized TMS/TDI/TDO_DR traffic against a table-driven
//               reference model of the TAP and instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_controller;
    import jtag_pkg::*;

`ifdef TAP_IDCODE_RESET_EN
    localparam logic [2:0] RST_INSTR = 3'b101;
`else
    localparam logic [2:0] RST_INSTR = 3'b111;
`endif

    logic       TCK = 1'b0;
    logic       reset = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO_DR = 1'b0;
    logic       TDO;
    logic       enableTDO;
    logic       shiftDR;
    logic       clockDR;
    logic       updateDR;
    logic [2:0] instruction;
    logic [3:0] tap_state;

    int checks = 0;
    int failures = 0;

    // Reference model: TAP graph as two lookup tables plus IR/TDO state.
    tap_state_t nxt0 [16];
    tap_state_t nxt1 [16];
    tap_state_t m_state;
    logic [2:0] m_ir;
    logic [2:0] m_instr;
    logic       m_tdo;
    logic       m_en;

    tap_controller dut (
        .TCK         (TCK),
        .reset       (reset),
        .TMS         (TMS),
        .TDI         (TDI),
        .TDO_DR      (TDO_DR),
        .TDO         (TDO),
        .enableTDO   (enableTDO),
        .shiftDR     (shiftDR),
        .clockDR     (clockDR),
        .updateDR    (updateDR),
        .instruction (instruction),
        .tap_state   (tap_state)
    );

    always #5 TCK = ~TCK;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    task automatic build_table();
        nxt0[TLR]   = RTI;     nxt1[TLR]   = TLR;
        nxt0[RTI]   = RTI;     nxt1[RTI]   = SelDR;
        nxt0[SelDR] = CapDR;   nxt1[SelDR] = SelIR;
        nxt0[SelIR] = CapIR;   nxt1[SelIR] = TLR;
        nxt0[UpdDR] = RTI;     nxt1[UpdDR] = SelDR;
        nxt0[UpdIR] = RTI;     nxt1[UpdIR] = SelDR;
        nxt0[CapDR] = ShDR;    nxt1[CapDR] = Ex1DR;
        nxt0[CapIR] = ShIR;    nxt1[CapIR] = Ex1IR;
        nxt0[ShDR]  = ShDR;    nxt1[ShDR]  = Ex1DR;
        nxt0[ShIR]  = ShIR;    nxt1[ShIR]  = Ex1IR;
        nxt0[Ex1DR] = PauseDR; nxt1[Ex1DR] = UpdDR;
        nxt0[Ex1IR] = PauseIR; nxt1[Ex1IR] = UpdIR;
        nxt0[PauseDR] = PauseDR; nxt1[PauseDR] = Ex2DR;
        nxt0[PauseIR] = PauseIR; nxt1[PauseIR] = Ex2IR;
        nxt0[Ex2DR] = ShDR;    nxt1[Ex2DR] = UpdDR;
        nxt0[Ex2IR] = ShIR;    nxt1[Ex2IR] = UpdIR;
    endtask

    // Advance the model by one rising edge using the inputs the DUT saw.
    task automatic model_edge(input logic r, input logic t, input logic d, input logic dd);
        tap_state_t ns;
        if (r) begin
            m_state = TLR;
            m_ir    = 3'b001;
            m_instr = RST_INSTR;
            m_tdo   = 1'b0;
            m_en    = 1'b0;
        end else begin
            ns = t ? nxt1[m_state] : nxt0[m_state];
            if (m_state == ShIR) begin
                m_tdo = m_ir[0];
                m_en  = 1'b1;
            end else if (m_state == ShDR) begin
                m_tdo = dd;
                m_en  = 1'b1;
            end else begin
                m_en  = 1'b0;
            end
            if (m_state == UpdIR) m_instr = m_ir;
            if (m_state == CapIR) m_ir = 3'b001;
            else if (m_state == ShIR) m_ir = 3'(m_ir / 2 + (d ? 4 : 0));
            if (ns == TLR) m_instr = RST_INSTR;
            m_state = ns;
        end
    endtask

    // Drive inputs, take one rising edge, update the model, settle 1 time unit.
    task automatic tick(input logic r, input logic t, input logic d, input logic dd);
        reset  = r;
        TMS    = t;
        TDI    = d;
        TDO_DR = dd;
        @(posedge TCK);
        model_edge(r, t, d, dd);
        #1;
    endtask

    // From RTI: load value v (shifted LSB first) into the instruction, end in RTI.
    task automatic load_ir(input logic [2:0] v);
        tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 0, v[0], 0); tick(0, 0, v[1], 0); tick(0, 1, v[2], 0);
        tick(0, 1, 0, 0); tick(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 1);
        checks++; if (tap_state !== TLR) begin failures++; $display("FAIL reset_state got=%0h exp=%0h", tap_state, TLR); end
        checks++; if (instruction !== RST_INSTR) begin failures++; $display("FAIL reset_instr got=%b exp=%b", instruction, RST_INSTR); end
        checks++; if ({TDO, enableTDO, shiftDR, clockDR, updateDR} !== 5'b00010) begin failures++;
            $display("FAIL reset_outputs got=%b exp=00010", {TDO, enableTDO, shiftDR, clockDR, updateDR}); end
        tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        checks++; if (tap_state !== RTI) begin failures++; $display("FAIL rti_state got=%0h exp=%0h", tap_state, RTI); end
        checks++; if (instruction !== RST_INSTR || enableTDO !== 1'b0 || clockDR !== 1'b1) begin failures++;
            $display("FAIL rti_outputs instr=%b en=%b clockDR=%b exp instr=%b en=0 clockDR=1", instruction, enableTDO, clockDR, RST_INSTR); end
    endtask

    task automatic test_ir_capture_shift();
        logic [2:0] o;
        tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        checks++; if (tap_state !== ShIR || enableTDO !== 1'b0) begin failures++;
            $display("FAIL ir_enter_shift state=%0h en=%b exp state=%0h en=0", tap_state, enableTDO, ShIR); end
        tick(0, 0, 0, 0); o[0] = TDO;
        checks++; if (enableTDO !== 1'b1) begin failures++; $display("FAIL ir_shift_enable got=%b exp=1", enableTDO); end
        tick(0, 0, 0, 0); o[1] = TDO;
        tick(0, 1, 0, 0); o[2] = TDO;
        checks++; if (o !== 3'b001) begin failures++; $display("FAIL ir_capture_tdo got(first..last)=%b%b%b exp=100", o[0], o[1], o[2]); end
        tick(0, 1, 0, 0);
        checks++; if (tap_state !== UpdIR || instruction !== RST_INSTR) begin failures++;
            $display("FAIL ir_upd_hold state=%0h instr=%b exp state=%0h instr=%b", tap_state, instruction, UpdIR, RST_INSTR); end
        tick(0, 0, 0, 0);
        checks++; if (instruction !== 3'b000) begin failures++; $display("FAIL ir_update got=%b exp=000", instruction); end
    endtask

    task automatic test_dr_shift();
        tick(0, 1, 0, 0); tick(0, 0, 0, 0);
        checks++; if (tap_state !== CapDR || clockDR !== 1'b0 || shiftDR !== 1'b0) begin failures++;
            $display("FAIL dr_capture state=%0h clockDR=%b shiftDR=%b exp %0h 0 0", tap_state, clockDR, shiftDR, CapDR); end
        tick(0, 0, 0, 0);
        checks++; if (shiftDR !== 1'b1 || clockDR !== 1'b0) begin failures++;
            $display("FAIL dr_shift_ctl shiftDR=%b clockDR=%b exp 1 0", shiftDR, clockDR); end
        tick(0, 0, 0, 1);
        checks++; if (TDO !== 1'b1 || enableTDO !== 1'b1) begin failures++; $display("FAIL dr_tdo0 tdo=%b en=%b exp 1 1", TDO, enableTDO); end
        tick(0, 0, 0, 0);
        checks++; if (TDO !== 1'b0) begin failures++; $display("FAIL dr_tdo1 got=%b exp=0", TDO); end
        tick(0, 1, 0, 1);
        checks++; if (TDO !== 1'b1 || tap_state !== Ex1DR || shiftDR !== 1'b0 || clockDR !== 1'b1) begin failures++;
            $display("FAIL dr_tdo2_exit tdo=%b state=%0h shiftDR=%b clockDR=%b exp 1 %0h 0 1", TDO, tap_state, shiftDR, clockDR, Ex1DR); end
        checks++; if (updateDR !== 1'b0) begin failures++; $display("FAIL upd_pre got=%b exp=0", updateDR); end
        tick(0, 1, 0, 0);
        checks++; if (updateDR !== 1'b1 || enableTDO !== 1'b0) begin failures++;
            $display("FAIL upd_pulse updateDR=%b en=%b exp 1 0", updateDR, enableTDO); end
        tick(0, 0, 0, 0);
        checks++; if (updateDR !== 1'b0 || tap_state !== RTI) begin failures++;
            $display("FAIL upd_post updateDR=%b state=%0h exp 0 %0h", updateDR, tap_state, RTI); end
    endtask

    task automatic test_five_ones();
        // From ShDR (instruction currently non-reset).
        tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        checks++; if (tap_state !== ShDR) begin failures++; $display("FAIL tlr_pre_shdr got=%0h exp=%0h", tap_state, ShDR); end
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        checks++; if (tap_state !== TLR || instruction !== RST_INSTR) begin failures++;
            $display("FAIL tlr_from_shdr state=%0h instr=%b exp %0h %b", tap_state, instruction, TLR, RST_INSTR); end
        // From PauseIR.
        tick(0, 0, 0, 0);
        load_ir(SAMPLE_PRELOAD);
        checks++; if (instruction !== SAMPLE_PRELOAD) begin failures++; $display("FAIL load_sample got=%b exp=%b", instruction, SAMPLE_PRELOAD); end
        tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0);
        checks++; if (tap_state !== PauseIR) begin failures++; $display("FAIL tlr_pre_pauseir got=%0h exp=%0h", tap_state, PauseIR); end
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        checks++; if (tap_state !== TLR || instruction !== RST_INSTR) begin failures++;
            $display("FAIL tlr_from_pauseir state=%0h instr=%b exp %0h %b", tap_state, instruction, TLR, RST_INSTR); end
        // From Ex2DR.
        tick(0, 0, 0, 0);
        load_ir(RUNBIST);
        checks++; if (instruction !== RUNBIST) begin failures++; $display("FAIL load_runbist got=%b exp=%b", instruction, RUNBIST); end
        tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
        checks++; if (tap_state !== Ex2DR) begin failures++; $display("FAIL tlr_pre_ex2dr got=%0h exp=%0h", tap_state, Ex2DR); end
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        checks++; if (tap_state !== TLR || instruction !== RST_INSTR) begin failures++;
            $display("FAIL tlr_from_ex2dr state=%0h instr=%b exp %0h %b", tap_state, instruction, TLR, RST_INSTR); end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_shift();
        load_ir(INTEST);
        tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 0, 1, 0); tick(0, 1, 0, 0); tick(0, 0, 1, 0);
        checks++; if (tap_state !== PauseIR || instruction !== INTEST) begin failures++;
            $display("FAIL midshift_pause state=%0h instr=%b exp %0h %b", tap_state, instruction, PauseIR, INTEST); end
        tick(1, 0, 1, 0);
        checks++; if (tap_state !== TLR || instruction !== RST_INSTR) begin failures++;
            $display("FAIL midshift_reset state=%0h instr=%b exp %0h %b", tap_state, instruction, TLR, RST_INSTR); end
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);
        checks++; if (tap_state !== RTI || instruction !== RST_INSTR) begin failures++;
            $display("FAIL midshift_after state=%0h instr=%b exp %0h %b", tap_state, instruction, RTI, RST_INSTR); end
    endtask

    task automatic test_pause_hold();
        logic [2:0] b;
        for (int n = 0; n < 4; n++) begin
            b = 3'($urandom_range(0, 7));
            tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
            tick(0, 0, b[0], 0); tick(0, 1, b[1], 0);
            tick(0, 0, 1'($urandom), 0); tick(0, 0, 1'($urandom), 0); tick(0, 0, 1'($urandom), 0);
            checks++; if (tap_state !== PauseIR || enableTDO !== 1'b0) begin failures++;
                $display("FAIL pause_state state=%0h en=%b exp %0h 0", tap_state, enableTDO, PauseIR); end
            tick(0, 1, 1'($urandom), 0); tick(0, 0, 1'($urandom), 0);
            tick(0, 1, b[2], 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0);
            checks++; if (instruction !== b) begin failures++; $display("FAIL pause_update iter=%0d got=%b exp=%b", n, instruction, b); end
        end
    endtask

    task automatic test_random();
        logic r;
        logic [11:0] got;
        logic [11:0] exp;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            tick(r, 1'($urandom), 1'($urandom), 1'($urandom));
            got = {tap_state, instruction, TDO, enableTDO, shiftDR, clockDR, updateDR};
            exp = {4'(m_state), m_instr, m_tdo, m_en, m_state == ShDR,
                   !(m_state == CapDR || m_state == ShDR), m_state == UpdDR};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random cycle=%0d {state,instr,tdo,en,shDR,clkDR,updDR} got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    initial begin
        build_table();
        test_reset();
        test_ir_capture_shift();
        test_dr_shift();
        test_five_ones();
        test_reset_mid_shift();
        test_pause_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine plus instruction register (IR) for the boundary-scan chain.
- Sequences the JTAG datapath: drives shiftDR/clockDR/updateDR and the latched instruction into the instruction decoder; muxes the IR or DR serial output onto TDO.
- Single clock domain. TCK is the system clock here; state advances on the rising edge.

Parameters:
- IR_size, 3, instruction register width in bits (≥2).
- IR_CAPTURE, 3'b001, value loaded into the IR shift stage in Capture-IR; the two LSBs must be 01.
- BYPASS, 3'b111, instruction loaded at reset (all ones).
- IDCODE, 3'b101, opcode used by the optional feature.

Ports:
- TCK, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, synchronous active-high reset; forces Test-Logic-Reset.
- TMS, input, 1, test mode select; sampled every rising edge.
- TDI, input, 1, serial test data in.
- TDO_DR, input, 1, serial output of the selected data register (bypass/BSC/ID).
- TDO, output, 1, registered serial test data out.
- enableTDO, output, 1, TDO driver enable; 1 only in Shift-IR/Shift-DR.
- shiftDR, output, 1, 1 in Shift-DR.
- clockDR, output, 1, DR clock-enable, idle high; 0 in Capture-DR and Shift-DR.
- updateDR, output, 1, single-cycle pulse in Update-DR.
- instruction, output, IR_size, active instruction to the decoder.
- tap_state, output, 4, current state encoding, for debug and verification.

Behaviour:
- States, 4-bit encoding in the package: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Transitions follow 1149.1 exactly:
  - TLR: TMS=0 → RTI.
  - RTI/UpdDR/UpdIR: TMS=1 → SelDR, TMS=0 → RTI.
  - SelDR: TMS=0 → CapDR, TMS=1 → SelIR.
  - SelIR: TMS=0 → CapIR, TMS=1 → TLR.
  - Cap: TMS=0 → Sh, TMS=1 → Ex1.
  - Sh: TMS=0 stays, TMS=1 → Ex1.
  - Ex1: TMS=0 → Pause, TMS=1 → Upd.
  - Pause: TMS=0 stays, TMS=1 → Ex2.
  - Ex2: TMS=0 → Sh, TMS=1 → Upd.
- Five consecutive TMS=1 cycles reach TLR from any state.
- Reset (synchronous, priority over TMS), next-edge values:
  - state=TLR, instruction=BYPASS, IR shift stage=IR_CAPTURE.
  - TDO=0, enableTDO=0, shiftDR=0, clockDR=1, updateDR=0.
- While in TLR, instruction is held at BYPASS, same as reset.
- IR shift stage:
  - CapIR: load IR_CAPTURE.
  - ShIR: shift right each cycle; TDI enters the MSB; bit 0 is the serial output.
  - Pause/Exit states: hold.
- UpdIR: instruction ← IR shift stage, visible the cycle after UpdIR. instruction is stable in all other states.
- shiftDR, clockDR and updateDR are combinational decodes of the current state, so they carry no extra latency.
- TDO and enableTDO are registered, one cycle after the state:
  - In ShIR, TDO ← IR_shift[0].
  - In ShDR, TDO ← TDO_DR.
  - Otherwise TDO holds its last value and enableTDO=0.
- Reset asserted mid-shift: the shift is abandoned; the partial IR contents never reach instruction.

Optional Feature:
- Macro TAP_IDCODE_RESET_EN.
- Defined: reset and TLR load instruction=IDCODE (3'b101).
- Undefined: reset and TLR load BYPASS (3'b111).
- No other behaviour changes.

Decomposition:
- Package jtag_pkg:
  - tap_state_t enum with the 16 state encodings.
  - IR_size.
  - Opcodes BYPASS, EXTEST, SAMPLE_PRELOAD, INTEST, RUNBIST, IDCODE.
  - IR_CAPTURE.
- The package is shared with the instruction decoder.
- One natural sub-module: tap_fsm (state register, next-state logic, state decodes). tap_controller adds the IR and the TDO mux/register around it.

Test Plan:
- Reset, then TMS=0 for 3 cycles → state RTI; instruction=3'b111; enableTDO=0; clockDR=1.
- From RTI, TMS 1,1,0,0, then shift TDI bits 0,0,0 with the last on TMS=1, then TMS 1,0 → TDO emits 1,0,0 (captured 001); instruction=3'b000 one cycle after UpdIR.
- TMS=1 for 5 cycles from ShDR, PauseIR and Ex2DR each → state TLR; instruction=3'b111 (3'b101 with TAP_IDCODE_RESET_EN).
- From RTI, TMS 1,0,0 into ShDR with TDO_DR toggling 1,0,1 → shiftDR=1, clockDR=0, TDO follows TDO_DR one cycle later; updateDR pulses for exactly 1 cycle in UpdDR.
- Shift IR as far as PauseIR, then assert reset → next edge state=TLR, instruction=3'b111, previous instruction never altered by partial data.
- Traverse ShIR→Ex1IR→PauseIR(×3)→Ex2IR→ShIR → IR shift stage holds during pause; final UpdIR value matches all TDI bits shifted, pause-insensitive.
